// File: rtl/madd_acc_unit_pkg.sv
// Shared types and constants for the multiply-accumulate execution unit:
// ALU opcode encodings, reset level and FSM state encoding.
// Purely declarative; no timing or flow control of its own.
package madd_acc_unit_pkg;

    localparam int ALUOP_W = 8;
    localparam int DATA_W  = 32;
    localparam int PROD_W  = 64;

    localparam logic RST_ENABLE = 1'b1;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [ALUOP_W-1:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [ALUOP_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [ALUOP_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } mac_state_t;

    function automatic logic is_mac_op(input logic [ALUOP_W-1:0] op);
        return (op == EXE_MADD_OP)  || (op == EXE_MADDU_OP) ||
               (op == EXE_MSUB_OP)  || (op == EXE_MSUBU_OP);
    endfunction

    function automatic logic is_signed_op(input logic [ALUOP_W-1:0] op);
        return (op == EXE_MADD_OP) || (op == EXE_MSUB_OP);
    endfunction

    function automatic logic is_sub_op(input logic [ALUOP_W-1:0] op);
        return (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
    endfunction

endpackage

// File: rtl/madd_acc_unit_mult32x32.sv
// Combinational DATA_W x DATA_W multiplier, signed or unsigned per signed_i.
// Zero latency; no flow control. Replaceable by a pipelined multiplier later.
module madd_acc_unit_mult32x32
    import madd_acc_unit_pkg::*;
#(
    parameter int MUL_W = DATA_W
) (
    input  logic               signed_i,
    input  logic [MUL_W-1:0]   a_i,
    input  logic [MUL_W-1:0]   b_i,
    output logic [2*MUL_W-1:0] prod_o
);

    logic               a_neg;
    logic               b_neg;
    logic [MUL_W-1:0]   a_mag;
    logic [MUL_W-1:0]   b_mag;
    logic [2*MUL_W-1:0] prod_mag;

    // Magnitude multiply, then restore the sign; -(MIN) wraps to MIN, which is
    // still the correct unsigned magnitude.
    assign a_neg    = signed_i & a_i[MUL_W-1];
    assign b_neg    = signed_i & b_i[MUL_W-1];
    assign a_mag    = a_neg ? -a_i : a_i;
    assign b_mag    = b_neg ? -b_i : b_i;
    assign prod_mag = (2*MUL_W)'(a_mag) * (2*MUL_W)'(b_mag);
    assign prod_o   = (a_neg ^ b_neg) ? -prod_mag : prod_mag;

endmodule

// File: rtl/madd_acc_unit.sv
// EX-stage MADD/MADDU/MSUB/MSUBU unit: multiply, then accumulate into HI/LO.
// Latency: accept cycle 0, multiply cycle 1, HI/LO write cycle 2 (held while stall_i).
// Raises stallreq_o during accept and multiply; flush_i or reset drops the operation.
module madd_acc_unit
    import madd_acc_unit_pkg::*;
#(
    parameter int DATA_W = madd_acc_unit_pkg::DATA_W,
    parameter int PROD_W = madd_acc_unit_pkg::PROD_W
) (
    input  logic               clk,
    input  logic               Rst_n,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [DATA_W-1:0]  reg1_i,
    input  logic [DATA_W-1:0]  reg2_i,
    input  logic [DATA_W-1:0]  hi_i,
    input  logic [DATA_W-1:0]  lo_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               stallreq_o,
    output logic               whilo_o,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o,
    output logic               busy_o
);

    mac_state_t         state_q;
    mac_state_t         state_d;
    logic [ALUOP_W-1:0] op_q;
    logic [DATA_W-1:0]  opa_q;
    logic [DATA_W-1:0]  opb_q;
    logic [PROD_W-1:0]  prod_q;
    logic [PROD_W-1:0]  mult_prod;
    logic [PROD_W-1:0]  hilo;
    logic [PROD_W-1:0]  acc;
    logic               rst_act;
    logic               is_mac;
    logic               accept;

    assign rst_act = (Rst_n == RST_ENABLE);
    assign is_mac  = is_mac_op(aluop_i);
    assign accept  = (state_q == ST_IDLE) && is_mac && !flush_i;

    madd_acc_unit_mult32x32 #(
        .MUL_W    (DATA_W)
    ) u_mult (
        .signed_i (is_signed_op(op_q)),
        .a_i      (opa_q),
        .b_i      (opb_q),
        .prod_o   (mult_prod)
    );

    // HI/LO are read here rather than at accept so an older in-flight write is seen.
    assign hilo = {hi_i, lo_i};
    assign acc  = is_sub_op(op_q) ? (hilo - prod_q) : (hilo + prod_q);

    always_ff @(posedge clk) begin
        if (rst_act) begin
            state_q <= ST_IDLE;
            op_q    <= EXE_NOP_OP;
            opa_q   <= ZERO_WORD;
            opb_q   <= ZERO_WORD;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= aluop_i;
                opa_q <= reg1_i;
                opb_q <= reg2_i;
            end
            if (state_q == ST_MUL) begin
                prod_q <= mult_prod;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        stallreq_o = 1'b0;
        whilo_o    = 1'b0;
        hi_o       = ZERO_WORD;
        lo_o       = ZERO_WORD;
        busy_o     = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                stallreq_o = is_mac;
                if (accept) begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                stallreq_o = 1'b1;
                state_d    = flush_i ? ST_IDLE : ST_ACC;
            end
            ST_ACC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    whilo_o = 1'b1;
                    hi_o    = acc[PROD_W-1:DATA_W];
                    lo_o    = acc[DATA_W-1:0];
                    if (!stall_i) begin
                        state_d = ST_DONE;
                    end
                end
            end
            // One dead cycle so the instruction still on aluop_i is not re-accepted.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rst_act) begin
            stallreq_o = 1'b0;
            whilo_o    = 1'b0;
            hi_o       = ZERO_WORD;
            lo_o       = ZERO_WORD;
            busy_o     = 1'b0;
        end
    end

endmodule
